// File: rtl/rdma_sq_wrr_scheduler.sv
// Weighted round-robin scheduler moving per-region RDMA SQ commands onto the single
// network SQ, with per-region outstanding-command credit returned by completions.
module rdma_sq_wrr_scheduler #(
  parameter int N_REGIONS       = 4,
  parameter int VFID_BITS       = $clog2(N_REGIONS),
  parameter int REQ_BITS        = 128,
  parameter int WEIGHT_BITS     = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_REGIONS-1:0]          s_sq_valid,
  output logic [N_REGIONS-1:0]          s_sq_ready,
  input  logic [N_REGIONS*REQ_BITS-1:0] s_sq_data,
  output logic                          m_sq_valid,
  input  logic                          m_sq_ready,
  output logic [REQ_BITS-1:0]           m_sq_data,
  output logic [VFID_BITS-1:0]          m_sq_vfid,
  input  logic                          cq_valid,
  input  logic [VFID_BITS-1:0]          cq_vfid,
  input  logic                          cfg_we,
  input  logic [VFID_BITS-1:0]          cfg_vfid,
  input  logic [WEIGHT_BITS-1:0]        cfg_weight,
  output logic [N_REGIONS*CNT_BITS-1:0] outstanding,
  output logic                          cq_err
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  function automatic logic [VFID_BITS-1:0] wrap_inc(input logic [VFID_BITS-1:0] v);
    logic [VFID_BITS-1:0] r;
    if (int'(v) == N_REGIONS - 1) r = '0;
    else r = v + VFID_BITS'(1);
    return r;
  endfunction

  function automatic logic [WEIGHT_BITS:0] burst_count(input logic same_region,
                                                      input logic [WEIGHT_BITS-1:0] b);
    logic [WEIGHT_BITS:0] r;
    if (same_region) r = {1'b0, b} + (WEIGHT_BITS+1)'(1);
    else r = (WEIGHT_BITS+1)'(1);
    return r;
  endfunction

  state_t                 state, state_nxt;
  logic [WEIGHT_BITS-1:0] weight    [N_REGIONS];
  logic [CNT_BITS-1:0]    outst_cnt [N_REGIONS];
  logic [CNT_BITS-1:0]    cnt_nxt   [N_REGIONS];
  logic [VFID_BITS-1:0]   rr_ptr, rr_ptr_nxt;
  logic [WEIGHT_BITS-1:0] burst_cnt, burst_nxt;
  logic [WEIGHT_BITS:0]   count;
  logic [N_REGIONS-1:0]   eligible;
  logic [N_REGIONS-1:0]   inc_vec, dec_vec;
  logic                   found;
  logic [VFID_BITS-1:0]   sel;
  logic                   capture, handshake;
  logic                   cq_hit, cq_err_set, cfg_hit;
  logic [REQ_BITS-1:0]    data_p1;
  logic [VFID_BITS-1:0]   vfid_p1;

  always_comb begin
    for (int i = 0; i < N_REGIONS; i++) begin
      eligible[i] = s_sq_valid[i] && (weight[i] != '0) &&
                    (outst_cnt[i] < CNT_BITS'(MAX_OUTSTANDING));
    end
  end

  // Circular priority scan starting at rr_ptr; the first eligible region wins.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    for (int k = 0; k < N_REGIONS; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= N_REGIONS) idx = idx - N_REGIONS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = VFID_BITS'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    s_sq_ready = '0;
    capture    = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        // Ready is withheld during reset so no command is accepted and then lost.
        if (found && !areset) begin
          s_sq_ready[sel] = 1'b1;
          capture         = 1'b1;
          state_nxt       = SEND;
        end
      end
      SEND: begin
        if (m_sq_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count      = burst_count(sel == rr_ptr, burst_cnt);
    rr_ptr_nxt = sel;
    burst_nxt  = count[WEIGHT_BITS-1:0];
    if (count >= {1'b0, weight[sel]}) begin
      rr_ptr_nxt = wrap_inc(sel);
      burst_nxt  = '0;
    end
  end

  // A same-cycle grant and completion for one region cancel; a completion with
  // nothing outstanding (or for a nonexistent region) only flags the error.
  always_comb begin
    cq_hit     = cq_valid && (int'(cq_vfid) < N_REGIONS);
    cfg_hit    = cfg_we && (int'(cfg_vfid) < N_REGIONS);
    cq_err_set = cq_valid && !cq_hit;
    inc_vec    = '0;
    dec_vec    = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      inc_vec[i] = handshake && (int'(vfid_p1) == i);
      if (cq_hit && (int'(cq_vfid) == i)) begin
        if (outst_cnt[i] == '0) cq_err_set = 1'b1;
        else dec_vec[i] = 1'b1;
      end
      cnt_nxt[i] = outst_cnt[i];
      if (inc_vec[i] && !dec_vec[i]) cnt_nxt[i] = outst_cnt[i] + CNT_BITS'(1);
      else if (dec_vec[i] && !inc_vec[i]) cnt_nxt[i] = outst_cnt[i] - CNT_BITS'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      cq_err    <= 1'b0;
      for (int i = 0; i < N_REGIONS; i++) begin
        weight[i]    <= WEIGHT_BITS'(1);
        outst_cnt[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (capture) begin
        rr_ptr    <= rr_ptr_nxt;
        burst_cnt <= burst_nxt;
      end
      if (cfg_hit) weight[cfg_vfid] <= cfg_weight;
      if (cq_err_set) cq_err <= 1'b1;
      for (int i = 0; i < N_REGIONS; i++) outst_cnt[i] <= cnt_nxt[i];
    end
  end

  // Stage p1: granted command held stable for the network SQ until accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      data_p1 <= '0;
      vfid_p1 <= '0;
    end else if (capture) begin
      data_p1 <= s_sq_data[int'(sel)*REQ_BITS +: REQ_BITS];
      vfid_p1 <= sel;
    end
  end

  assign m_sq_valid = (state == SEND);
  assign m_sq_data  = data_p1;
  assign m_sq_vfid  = vfid_p1;

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_outst
    assign outstanding[g*CNT_BITS +: CNT_BITS] = outst_cnt[g];
  end

endmodule

// File: tb/tb_rdma_sq_wrr_scheduler.sv
// Bench for rdma_sq_wrr_scheduler: grant-order tables, hand-built corner sequences and
// randomized traffic checked every cycle against a behavioural model of the scheduler.
module tb_rdma_sq_wrr_scheduler;
  localparam int N    = 4;
  localparam int VB   = 2;
  localparam int RB   = 128;
  localparam int WB   = 4;
  localparam int MAXO = 16;
  localparam int CB   = 5;

  typedef logic [127:0] w_t;

  logic            aclk, areset;
  logic [N-1:0]    s_sq_valid, s_sq_ready;
  logic [N*RB-1:0] s_sq_data;
  logic            m_sq_valid, m_sq_ready;
  logic [RB-1:0]   m_sq_data;
  logic [VB-1:0]   m_sq_vfid;
  logic            cq_valid;
  logic [VB-1:0]   cq_vfid;
  logic            cfg_we;
  logic [VB-1:0]   cfg_vfid;
  logic [WB-1:0]   cfg_weight;
  logic [N*CB-1:0] outstanding;
  logic            cq_err;

  rdma_sq_wrr_scheduler dut (
    .aclk(aclk), .areset(areset),
    .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
    .m_sq_vfid(m_sq_vfid), .cq_valid(cq_valid), .cq_vfid(cq_vfid),
    .cfg_we(cfg_we), .cfg_vfid(cfg_vfid), .cfg_weight(cfg_weight),
    .outstanding(outstanding), .cq_err(cq_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the scheduler owes each region, kept as plain numbers.
  bit          model_ok = 0;
  bit          mb_busy;
  int          mb_ptr, mb_burst, mb_vfid;
  logic [RB-1:0] mb_data;
  bit          mb_err;
  int          mw[N];
  int          mo[N];

  int  log_q[$];
  int  cap_cnt = 0;
  int  cyc_no = 0;
  int  last_hs = -100;
  bit  prev_ready = 0;

  typedef struct {
    logic [15:0] w;      // weight of region i at [4*i +: 4]
    logic [3:0]  valid;
    logic [47:0] seq;    // expected grant k at nibble [47-4*k -: 4]
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input w_t act, input w_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < N * RB / 32; i++) s_sq_data[i*32 +: 32] = $urandom;
  endtask

  task automatic step();
    int sel;
    logic [N-1:0] exp_ready;
    int no[N];
    int cnt;
    #2;
    sel = -1;
    if (!mb_busy && !areset) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mb_ptr + k) % N;
        if (sel < 0 && s_sq_valid[i] && mw[i] != 0 && mo[i] < MAXO) sel = i;
      end
    end
    exp_ready = '0;
    if (sel >= 0) exp_ready[sel] = 1'b1;
    if (model_ok) begin
      chk("s_sq_ready", w_t'(s_sq_ready), w_t'(exp_ready));
      chk("m_sq_valid", w_t'(m_sq_valid), w_t'(mb_busy));
      chk("m_sq_data", w_t'(m_sq_data), w_t'(mb_data));
      chk("m_sq_vfid", w_t'(m_sq_vfid), w_t'(mb_vfid));
      for (int i = 0; i < N; i++)
        chk($sformatf("outstanding%0d", i), w_t'(outstanding[i*CB +: CB]), w_t'(mo[i]));
      chk("cq_err", w_t'(cq_err), w_t'(mb_err));
      if (prev_ready) chk("ready_pulse_width", w_t'(s_sq_ready), w_t'(0));
    end
    if (m_sq_valid && m_sq_ready && !areset) begin
      log_q.push_back(int'(m_sq_vfid));
      chk("handshake_spacing", w_t'(cyc_no - last_hs >= 2), w_t'(1));
      last_hs = cyc_no;
    end
    if (|s_sq_ready) cap_cnt++;
    prev_ready = |s_sq_ready;

    if (areset) begin
      mb_busy = 0; mb_ptr = 0; mb_burst = 0; mb_vfid = 0; mb_data = '0; mb_err = 0;
      for (int i = 0; i < N; i++) begin mw[i] = 1; mo[i] = 0; end
      model_ok = 1;
    end else begin
      for (int i = 0; i < N; i++) no[i] = mo[i];
      if (mb_busy && m_sq_ready) begin
        no[mb_vfid]++;
        mb_busy = 0;
      end else if (sel >= 0) begin
        mb_busy = 1;
        mb_vfid = sel;
        mb_data = s_sq_data[sel*RB +: RB];
        cnt = (sel != mb_ptr) ? 1 : mb_burst + 1;
        if (cnt >= mw[sel]) begin mb_ptr = (sel + 1) % N; mb_burst = 0; end
        else begin mb_ptr = sel; mb_burst = cnt; end
      end
      if (cq_valid) begin
        if (int'(cq_vfid) >= N || mo[cq_vfid] == 0) mb_err = 1;
        else no[cq_vfid]--;
      end
      for (int i = 0; i < N; i++) mo[i] = no[i];
      if (cfg_we && int'(cfg_vfid) < N) mw[cfg_vfid] = int'(cfg_weight);
    end
    @(posedge aclk);
    #1;
    cyc_no++;
  endtask

  task automatic idle_inputs();
    s_sq_valid = '0; m_sq_ready = 1'b0; cq_valid = 1'b0; cq_vfid = '0;
    cfg_we = 1'b0; cfg_vfid = '0; cfg_weight = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    step();
    areset = 1'b0;
  endtask

  task automatic wait_send(input string name);
    int w;
    w = 0;
    while (!m_sq_valid && w < 20) begin rand_data(); step(); w++; end
    if (!m_sq_valid) chk({name, "_wait_timeout"}, w_t'(m_sq_valid), w_t'(1));
  endtask

  task automatic run_vec(input int vi);
    do_reset();
    for (int i = 0; i < N; i++) begin
      cfg_we = 1'b1; cfg_vfid = VB'(i); cfg_weight = vecs[vi].w[i*4 +: 4];
      step();
    end
    cfg_we = 1'b0;
    log_q.delete();
    s_sq_valid = vecs[vi].valid;
    m_sq_ready = 1'b1;
    for (int c = 0; c < 80 && log_q.size() < 12; c++) begin rand_data(); step(); end
    chk($sformatf("vec%0d_count", vi), w_t'(log_q.size()), w_t'(12));
    for (int k = 0; k < 12; k++)
      if (k < log_q.size())
        chk($sformatf("vec%0d_grant%0d", vi, k), w_t'(log_q[k]), w_t'(vecs[vi].seq[47-4*k -: 4]));
    idle_inputs();
  endtask

  initial begin
    logic [RB-1:0] cap_data;
    int w;
    areset = 1'b0;
    idle_inputs();
    s_sq_data = '0;
    vecs[0] = '{w: 16'h1111, valid: 4'hF, seq: 48'h012301230123};
    vecs[1] = '{w: 16'h2013, valid: 4'hF, seq: 48'h000133000133};
    vecs[2] = '{w: 16'h2222, valid: 4'hA, seq: 48'h113311331133};
    vecs[3] = '{w: 16'h1141, valid: 4'h7, seq: 48'h011112011112};
    @(posedge aclk);
    #1;

    do_reset();
    chk("reset_m_sq_valid", w_t'(m_sq_valid), w_t'(0));
    chk("reset_m_sq_data", w_t'(m_sq_data), w_t'(0));
    chk("reset_outstanding", w_t'(outstanding), w_t'(0));
    chk("reset_cq_err", w_t'(cq_err), w_t'(0));

    for (int v = 0; v < 4; v++) run_vec(v);

    // Credit limit: 16 grants, then blocked until one completion returns a credit.
    do_reset();
    s_sq_valid = 4'b0010; m_sq_ready = 1'b1; log_q.delete();
    repeat (60) begin rand_data(); step(); end
    chk("limit_grants", w_t'(log_q.size()), w_t'(16));
    chk("limit_out1", w_t'(outstanding[1*CB +: CB]), w_t'(16));
    cap_cnt = 0;
    repeat (10) step();
    chk("limit_ready_blocked", w_t'(cap_cnt), w_t'(0));
    cq_valid = 1'b1; cq_vfid = 2'd1; step(); cq_valid = 1'b0;
    repeat (10) begin rand_data(); step(); end
    chk("limit_grants_after_cq", w_t'(log_q.size()), w_t'(17));
    chk("limit_out1_after_cq", w_t'(outstanding[1*CB +: CB]), w_t'(16));

    // Backpressure: output held stable for 10 cycles, no upstream ready, no credit taken.
    do_reset();
    s_sq_valid = 4'b0001; m_sq_ready = 1'b0; rand_data();
    cap_data = s_sq_data[0 +: RB];
    step();
    chk("bp_capture_data", w_t'(m_sq_data), w_t'(cap_data));
    for (int c = 0; c < 10; c++) begin
      rand_data(); step();
      chk("bp_valid", w_t'(m_sq_valid), w_t'(1));
      chk("bp_data", w_t'(m_sq_data), w_t'(cap_data));
      chk("bp_vfid", w_t'(m_sq_vfid), w_t'(0));
      chk("bp_ready", w_t'(s_sq_ready), w_t'(0));
      chk("bp_out0", w_t'(outstanding[0 +: CB]), w_t'(0));
    end
    m_sq_ready = 1'b1; step(); m_sq_ready = 1'b0; s_sq_valid = '0;
    chk("bp_out0_after_hs", w_t'(outstanding[0 +: CB]), w_t'(1));
    step();

    // Same-cycle grant and completion cancel; completion with no credit flags an error.
    do_reset();
    s_sq_valid = 4'b0100;
    for (int n = 0; n < 6; n++) begin
      wait_send("cq_same");
      m_sq_ready = 1'b1;
      if (n == 5) begin cq_valid = 1'b1; cq_vfid = 2'd2; end
      step();
      m_sq_ready = 1'b0; cq_valid = 1'b0;
    end
    s_sq_valid = '0;
    chk("cq_same_out2", w_t'(outstanding[2*CB +: CB]), w_t'(5));
    chk("cq_same_no_err", w_t'(cq_err), w_t'(0));
    cq_valid = 1'b1; cq_vfid = 2'd3; step(); cq_valid = 1'b0;
    chk("cq_zero_err", w_t'(cq_err), w_t'(1));
    chk("cq_zero_out3", w_t'(outstanding[3*CB +: CB]), w_t'(0));
    step();
    chk("cq_err_sticky", w_t'(cq_err), w_t'(1));

    // Weight cut mid-burst ends the burst at the next grant; then reset during SEND.
    do_reset();
    cfg_we = 1'b1; cfg_vfid = 2'd0; cfg_weight = 4'd4; step(); cfg_we = 1'b0;
    s_sq_valid = 4'b0011; m_sq_ready = 1'b1; log_q.delete(); cap_cnt = 0;
    w = 0;
    while (cap_cnt < 2 && w < 20) begin rand_data(); step(); w++; end
    chk("wcut_two_captures", w_t'(cap_cnt), w_t'(2));
    cfg_we = 1'b1; cfg_vfid = 2'd0; cfg_weight = 4'd1; step(); cfg_we = 1'b0;
    w = 0;
    while (log_q.size() < 4 && w < 20) begin rand_data(); step(); w++; end
    chk("wcut_count", w_t'(log_q.size()), w_t'(4));
    for (int k = 0; k < 4; k++)
      if (k < log_q.size()) chk($sformatf("wcut_grant%0d", k), w_t'(log_q[k]), w_t'(k == 3 ? 1 : 0));
    m_sq_ready = 1'b0;
    wait_send("rst_send");
    areset = 1'b1; step(); areset = 1'b0; s_sq_valid = '0;
    chk("rst_send_valid", w_t'(m_sq_valid), w_t'(0));
    chk("rst_send_data", w_t'(m_sq_data), w_t'(0));
    chk("rst_send_vfid", w_t'(m_sq_vfid), w_t'(0));
    chk("rst_send_outstanding", w_t'(outstanding), w_t'(0));
    chk("rst_send_cq_err", w_t'(cq_err), w_t'(0));
    step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s_sq_valid = 4'($urandom);
      m_sq_ready = ($urandom_range(0, 9) < 7);
      cq_valid   = ($urandom_range(0, 3) == 0);
      cq_vfid    = 2'($urandom);
      cfg_we     = ($urandom_range(0, 49) == 0);
      cfg_vfid   = 2'($urandom);
      cfg_weight = 4'($urandom_range(0, 5));
      areset     = ($urandom_range(0, 799) == 0);
      rand_data();
      step();
    end
    areset = 1'b0;
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rdma_sq_wrr_scheduler.md
Name: rdma_sq_wrr_scheduler

Overview:
Weighted round-robin scheduler for RDMA send-queue (SQ) commands from N_REGIONS user regions onto the single network SQ. Each region has a per-region outstanding-command limit. Completions (CQ) return the region's credit. Sits between the per-region user SQ interfaces and the network-side SQ, ahead of the TX meta arbitration that tags outgoing data with the source vfid.

Parameters:
N_REGIONS, 4, number of user regions (2..16)
VFID_BITS, $clog2(N_REGIONS), region index width
REQ_BITS, 128, SQ command payload width
WEIGHT_BITS, 4, per-region weight width
MAX_OUTSTANDING, 16, per-region limit on unacknowledged commands
CNT_BITS, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
s_sq_valid  in  N_REGIONS  per-region command valid
s_sq_ready  out  N_REGIONS  per-region command ready (at most one bit high)
s_sq_data  in  N_REGIONS*REQ_BITS  per-region command, region i at [i*REQ_BITS +: REQ_BITS]
m_sq_valid  out  1  network SQ valid
m_sq_ready  in  1  network SQ ready
m_sq_data  out  REQ_BITS  granted command
m_sq_vfid  out  VFID_BITS  source region of m_sq_data
cq_valid  in  1  completion pulse, one per finished command
cq_vfid  in  VFID_BITS  region of completion
cfg_we  in  1  weight write strobe
cfg_vfid  in  VFID_BITS  region whose weight is written
cfg_weight  in  WEIGHT_BITS  new weight; 0 disables region
outstanding  out  N_REGIONS*CNT_BITS  per-region outstanding counters
cq_err  out  1  sticky: completion arrived for region with zero outstanding

Behaviour:
- Reset: s_sq_ready=0, m_sq_valid=0, m_sq_data=0, m_sq_vfid=0, outstanding all 0, cq_err=0, weights all 1, rr_ptr=0, burst_cnt=0, FSM=IDLE.
- Eligible(i) = s_sq_valid[i] && weight[i]!=0 && outstanding[i]<MAX_OUTSTANDING.
- FSM IDLE: sel = first eligible region scanning circularly from rr_ptr. If none, stay IDLE with s_sq_ready=0. Otherwise s_sq_ready[sel]=1 combinationally for that cycle; s_sq_data[sel] and sel are captured into output registers; go to SEND.
- FSM SEND: m_sq_valid=1; m_sq_data/m_sq_vfid held stable until m_sq_ready. On handshake: outstanding[vfid]+=1; go to IDLE. All s_sq_ready=0 in SEND. Throughput is 1 command per 2 cycles minimum.
- Burst accounting, updated at capture in IDLE:
  - If sel!=rr_ptr, rr_ptr:=sel and count=1; otherwise count=burst_cnt+1.
  - If count>=weight[sel], then rr_ptr:=(sel+1) mod N_REGIONS and burst_cnt:=0; else burst_cnt:=count.
  - Wrap: N_REGIONS-1 advances to 0.
- Weights: cfg_we writes weight[cfg_vfid] at the clock edge. The new value is used from the next IDLE decision. A weight reduced below the current burst_cnt terminates the burst at the next grant. Writes with cfg_vfid>=N_REGIONS are ignored.
- Completion: cq_valid decrements outstanding[cq_vfid] at the edge.
  - If outstanding is 0, the counter is unchanged and cq_err sets. cq_err clears only on reset.
  - Increment and decrement for the same region in the same cycle leave the counter unchanged.
  - cq_vfid>=N_REGIONS sets cq_err.
- Counter saturation cannot occur: the eligibility check prevents increment at MAX_OUTSTANDING.
- A region that drops s_sq_valid while not granted loses nothing. Once captured, a command is never dropped.
- Reset mid-SEND: the command is discarded and counters are cleared. Upstream must replay.

Test Plan:
1. Reset, then all 4 regions continuously valid with weights 1 -> m_sq_vfid sequence 0,1,2,3,0,…; each handshake spaced ≥2 cycles; each s_sq_ready pulse is 1 cycle wide.
2. Weights {3,1,0,2}, all valid, m_sq_ready=1 -> vfid sequence 0,0,0,1,3,3,0,0,0,…; region 2 is never granted.
3. Only region 1 valid, no CQ, MAX_OUTSTANDING=16 -> exactly 16 grants, then s_sq_ready[1] stays 0. One cq_valid with cq_vfid=1 -> exactly one further grant; outstanding[1] returns to 16.
4. m_sq_ready held 0 for 10 cycles during SEND -> m_sq_valid, m_sq_data and m_sq_vfid are stable for all 10 cycles; no s_sq_ready asserted; outstanding is unchanged until the handshake.
5. cq_valid for region 2 on the same cycle as its SEND handshake, with outstanding[2]=5 -> outstanding[2] stays 5. A later CQ to region 3 with outstanding 0 -> cq_err=1 and the counter stays 0.
6. Region 0 with weight 4 mid-burst at burst_cnt=2; write weight 1 -> the next grant to region 0 ends the burst and rr_ptr=1. Reset asserted during SEND -> m_sq_valid=0 the next cycle and all outputs at their reset values.
